times_table_axi_reader: RTL and testbench

//  AXI4-Lite read master sitting between the operand source and the times-table block RAM (blk_mem_gen_0).

---
 rtl/times_table_axi_reader_pkg.sv | 25 ++
 rtl/times_table_axi_reader_if.sv | 23 ++
 rtl/times_table_axi_reader_sat_counter.sv | 36 +++
 rtl/times_table_axi_reader.sv | 122 ++++++++++++
 tb/tb_times_table_axi_reader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/times_table_axi_reader_pkg.sv
// Shared types and defaults for the times-table AXI4-Lite read path.
package times_table_pkg;

  // Reader FSM: one read in flight at a time.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2,
    StOut  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_RES_W  = 6;
  localparam int unsigned DEF_LAT_W  = 8;
  localparam int unsigned OPND_W     = 3;

  // RAM word index for operand pair: a selects the row, b the column.
  function automatic logic [2*OPND_W-1:0] tt_index(logic [OPND_W-1:0] a, logic [OPND_W-1:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/times_table_axi_reader_if.sv
// AXI4-Lite read-channel bundle (AR + R) between the reader and the table RAM.
interface times_table_axi_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/times_table_axi_reader_sat_counter.sv
// Saturating up-counter used to measure request-to-response latency.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] base;
  logic [W-1:0] count_d;

  // clear and enable together restart the count at 1, so the start cycle is counted.
  always_comb begin
    base    = clear ? '0 : count_q;
    count_d = base;
    if (enable && (base != {W{1'b1}})) begin
      count_d = base + W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/times_table_axi_reader.sv
// AXI4-Lite read master: takes an (a,b) request, reads a*b from the times-table RAM,
// and returns it with error and latency status. One transaction outstanding.
module times_table_axi_reader
  import times_table_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RES_W  = DEF_RES_W,
  parameter int unsigned LAT_W  = DEF_LAT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OPND_W-1:0]    a,
  input  logic [OPND_W-1:0]    b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_W-1:0]     result,
  output logic                 res_err,
  output logic [LAT_W-1:0]     res_lat,
  output logic                 busy,
  times_table_axi_reader_if.master m_axi
);

  state_e            state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              res_valid_q;
  logic              res_err_q;
  logic [RES_W-1:0]  result_q;
  logic [LAT_W-1:0]  res_lat_q;

  logic              req_fire;
  logic              cnt_clear;
  logic              cnt_en;
  logic [LAT_W-1:0]  lat_cnt;
  logic              resp_bad;

  // Only the low RES_W bits of a read beat carry the product.
  logic unused_rdata;
  assign unused_rdata = ^m_axi.rdata[DATA_W-1:RES_W];

  // Handshake and counter control.
  always_comb begin
    req_ready = rst && (state_q == StIdle);
    req_fire  = req_valid && req_ready;
    cnt_clear = req_fire;
    cnt_en    = req_fire || (state_q == StAr) || (state_q == StR);
    resp_bad  = (m_axi.rresp != RESP_OKAY);
  end

  sat_counter #(
    .W (LAT_W)
  ) u_lat_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (lat_cnt)
  );

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      result_q    <= '0;
      res_lat_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_fire) begin
            araddr_q  <= ADDR_W'(tt_index(a, b));
            arvalid_q <= 1'b1;
            state_q   <= StAr;
          end
        end
        StAr: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StR;
          end
        end
        StR: begin
          if (m_axi.rvalid) begin
            // Error beats complete normally but never expose their data.
            result_q    <= resp_bad ? '0 : m_axi.rdata[RES_W-1:0];
            res_err_q   <= resp_bad;
            res_lat_q   <= lat_cnt;
            rready_q    <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= StOut;
          end
        end
        StOut: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign res_valid     = res_valid_q;
  assign res_err       = res_err_q;
  assign result        = result_q;
  assign res_lat       = res_lat_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_times_table_axi_reader.sv
// Directed + randomized bench for times_table_axi_reader with an in-bench RAM responder.
module tb_times_table_axi_reader;

  localparam int unsigned LatMax = 255;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] a;
  logic [2:0] b;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] result;
  logic       res_err;
  logic [7:0] res_lat;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  times_table_axi_reader_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  times_table_axi_reader #(
    .ADDR_W (32),
    .DATA_W (32),
    .RES_W  (6),
    .LAT_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .res_err   (res_err),
    .res_lat   (res_lat),
    .busy      (busy),
    .m_axi     (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // One full transaction. The RAM holds a*b at word {a,b}; upper data bits are noise.
  // Expected latency is the number of clock edges between the request and R handshakes.
  task automatic txn(input logic [2:0] ta, input logic [2:0] tb, input int ar_stall,
                     input int r_delay, input int hold, input logic [1:0] resp,
                     input bit spur, input string tag);
    int          c0;
    int          lat_exp;
    int          prod;
    logic [31:0] rd;
    logic [31:0] addr_exp;
    prod     = int'(ta) * int'(tb);
    addr_exp = 32'(ta) * 8 + 32'(tb);

    if (spur) begin
      axi.rvalid = 1'b1;
      axi.rdata  = $urandom;
      axi.rresp  = 2'b10;
      #1;
      chk(tag, "idle_rready", 32'(axi.rready), 0);
      tick();
      axi.rvalid = 1'b0;
    end

    chk(tag, "req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1;
    a = ta;
    b = tb;
    tick();
    c0 = cyc;
    req_valid = 1'b0;
    a = 3'($urandom);
    b = 3'($urandom);
    chk(tag, "arvalid", 32'(axi.arvalid), 1);
    chk(tag, "araddr", axi.araddr, addr_exp);
    chk(tag, "req_ready_busy", 32'(req_ready), 0);
    chk(tag, "busy", 32'(busy), 1);

    for (int i = 0; i < ar_stall; i++) begin
      axi.arready = 1'b0;
      if (spur) begin
        axi.rvalid = 1'b1;
        axi.rdata  = $urandom;
      end
      tick();
      if (i == 0 || i == ar_stall - 1) begin
        chk(tag, "arvalid_stall", 32'(axi.arvalid), 1);
        chk(tag, "araddr_stall", axi.araddr, addr_exp);
        chk(tag, "rready_in_ar", 32'(axi.rready), 0);
      end
    end
    axi.rvalid  = 1'b0;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk(tag, "arvalid_drop", 32'(axi.arvalid), 0);
    chk(tag, "rready_up", 32'(axi.rready), 1);

    for (int i = 0; i < r_delay; i++) begin
      if (spur) axi.arready = 1'b1;
      tick();
      chk(tag, "rready_wait", 32'(axi.rready), 1);
      chk(tag, "arvalid_in_r", 32'(axi.arvalid), 0);
    end
    axi.arready = 1'b0;

    if (resp == 2'b00) rd = ($urandom & 32'hFFFF_FFC0) | 32'(prod);
    else               rd = ($urandom & 32'hFFFF_FFC0) | 32'h3F;
    axi.rvalid = 1'b1;
    axi.rdata  = rd;
    axi.rresp  = resp;
    tick();
    axi.rvalid = 1'b0;
    lat_exp = cyc - c0;
    if (lat_exp > int'(LatMax)) lat_exp = int'(LatMax);

    chk(tag, "res_valid", 32'(res_valid), 1);
    chk(tag, "result", 32'(result), (resp == 2'b00) ? 32'(prod) : 0);
    chk(tag, "res_err", 32'(res_err), (resp == 2'b00) ? 0 : 1);
    chk(tag, "res_lat", 32'(res_lat), 32'(lat_exp));
    chk(tag, "rready_drop", 32'(axi.rready), 0);

    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      req_valid = 1'b1;
      a = 3'($urandom);
      b = 3'($urandom);
      tick();
      chk(tag, "hold_res_valid", 32'(res_valid), 1);
      chk(tag, "hold_result", 32'(result), (resp == 2'b00) ? 32'(prod) : 0);
      chk(tag, "hold_req_ready", 32'(req_ready), 0);
      chk(tag, "hold_arvalid", 32'(axi.arvalid), 0);
    end

    // Keep req_valid high across the drain edge: it must not be taken that cycle.
    res_ready = 1'b1;
    req_valid = 1'b1;
    tick();
    res_ready = 1'b0;
    req_valid = 1'b0;
    chk(tag, "drain_res_valid", 32'(res_valid), 0);
    chk(tag, "drain_busy", 32'(busy), 0);
    chk(tag, "drain_arvalid", 32'(axi.arvalid), 0);
    chk(tag, "drain_req_ready", 32'(req_ready), 1);
  endtask

  initial begin
    rst         = 1'b0;
    req_valid   = 1'b0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;

    // Reset state.
    tick();
    tick();
    chk("reset", "req_ready", 32'(req_ready), 0);
    chk("reset", "arvalid", 32'(axi.arvalid), 0);
    chk("reset", "rready", 32'(axi.rready), 0);
    chk("reset", "res_valid", 32'(res_valid), 0);
    chk("reset", "res_err", 32'(res_err), 0);
    chk("reset", "result", 32'(result), 0);
    chk("reset", "res_lat", 32'(res_lat), 0);
    chk("reset", "araddr", axi.araddr, 0);
    chk("reset", "busy", 32'(busy), 0);
    rst = 1'b1;
    #1;
    chk("reset", "req_ready_release", 32'(req_ready), 1);

    // Minimum-latency read, AR stall, output backpressure, error response.
    txn(3'd3, 3'd5, 0, 0, 0, 2'b00, 1'b0, "min_lat");
    txn(3'd3, 3'd5, 4, 0, 0, 2'b00, 1'b0, "ar_stall");
    txn(3'd6, 3'd7, 1, 2, 5, 2'b00, 1'b0, "backpressure");
    txn(3'd7, 3'd7, 0, 0, 0, 2'b10, 1'b0, "slverr");
    txn(3'd2, 3'd4, 1, 1, 0, 2'b11, 1'b1, "decerr");

    // Reset while waiting for the R beat.
    req_valid = 1'b1;
    a = 3'd4;
    b = 3'd2;
    tick();
    req_valid   = 1'b0;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("rst_mid", "in_r_rready", 32'(axi.rready), 1);
    rst = 1'b0;
    tick();
    chk("rst_mid", "arvalid", 32'(axi.arvalid), 0);
    chk("rst_mid", "rready", 32'(axi.rready), 0);
    chk("rst_mid", "res_valid", 32'(res_valid), 0);
    chk("rst_mid", "req_ready_low", 32'(req_ready), 0);
    chk("rst_mid", "busy", 32'(busy), 0);
    rst = 1'b1;
    #1;
    chk("rst_mid", "req_ready_release", 32'(req_ready), 1);
    txn(3'd4, 3'd2, 0, 0, 0, 2'b00, 1'b0, "after_rst");

    // Latency counter saturation.
    txn(3'd1, 3'd1, 300, 2, 0, 2'b00, 1'b0, "saturate");

    // Full sweep with random stalls and spurious handshake inputs.
    for (int i = 0; i < 64; i++) begin
      txn(3'(i / 8), 3'(i % 8), int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
          0, 2'b00, (i % 4) == 0, $sformatf("sweep%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
